pc_gen: RTL and testbench

Parameterised fetch-address generator for the pipelined MIPS core. It replaces the fixed-base program counter. The block holds a byte-address PC and selects the next PC from reset, exception entry, exception return, stall, jump/return and branch sources. It also keeps a small return-address stack (RAS) that predicts `jr $ra` targets, and flags fetch addresses the instruction memory cannot serve. It sits in front of IF and drives the instruction-memory index.

---
 rtl/pc_gen.sv | 92 +++++++++
 tb/tb_pc_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch PC generator: fixed-priority next-PC select plus a circular return-address stack.
// One-cycle redirect latency; Stall holds Pc and the RAS, and Exc_Req/Eret/Reset override it.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_ADDR   = 32'h0000_4180,
  parameter int                IM_WORDS   = 4096,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Stall,
  input  logic                        Br_Take,
  input  logic [ADDR_W-1:0]           Br_Target,
  input  logic                        Jump,
  input  logic [ADDR_W-1:0]           Jump_Target,
  input  logic                        Ret,
  input  logic                        Ras_Push,
  input  logic [ADDR_W-1:0]           Ras_Push_Addr,
  input  logic                        Exc_Req,
  input  logic                        Eret,
  input  logic [ADDR_W-1:0]           Epc_In,
  output logic [ADDR_W-1:0]           Pc,
  output logic [ADDR_W-1:0]           Pc_Plus4,
  output logic [$clog2(IM_WORDS)-1:0] Pc_Idx,
  output logic                        Adel,
  output logic                        Ras_Empty,
  output logic                        Ras_Full
);
  localparam int IDX_W = $clog2(IM_WORDS);
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W:0] IM_BYTES = (ADDR_W+1)'(IM_WORDS) << 2;
  localparam logic [RAS_W:0]  RAS_MAX  = (RAS_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_off;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [RAS_W-1:0]  tp_q;
  logic [RAS_W:0]    cnt_q;
  logic              ras_en;
  logic              do_push;
  logic              do_pop;

  assign Pc        = pc_q;
  assign Pc_Plus4  = pc_q + ADDR_W'(4);
  assign pc_off    = pc_q - RESET_ADDR;
  assign Pc_Idx    = pc_off[IDX_W+1:2];
  // Offset compare avoids overflow of RESET_ADDR + 4*IM_WORDS near the top of the address space.
  assign Adel      = (pc_q[1:0] != 2'b00) || (pc_q < RESET_ADDR) || ({1'b0, pc_off} >= IM_BYTES);
  assign Ras_Empty = (cnt_q == '0);
  assign Ras_Full  = (cnt_q == RAS_MAX);

  assign ras_en  = !(Reset || Exc_Req || Eret || Stall);
  assign do_push = ras_en && Ras_Push;
  assign do_pop  = ras_en && Ret && !Ras_Empty;

  always_comb begin
    pc_nxt = pc_q + ADDR_W'(4);
    if (Reset)          pc_nxt = RESET_ADDR;
    else if (Exc_Req)   pc_nxt = EXC_ADDR;
    else if (Eret)      pc_nxt = Epc_In;
    else if (Stall)     pc_nxt = pc_q;
    else if (Ret)       pc_nxt = Ras_Empty ? Jump_Target : ras_mem[tp_q];
    else if (Jump)      pc_nxt = Jump_Target;
    else if (Br_Take)   pc_nxt = Br_Target;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= RESET_ADDR;
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (do_push && !do_pop) begin
        tp_q <= tp_q + 1'b1;
        if (!Ras_Full) cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        tp_q  <= tp_q - 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Entries need no reset; push+pop rewrites the current top in place.
  always_ff @(posedge Clk) begin
    if (do_push && do_pop)  ras_mem[tp_q]        <= Ras_Push_Addr;
    else if (do_push)       ras_mem[tp_q + 1'b1] <= Ras_Push_Addr;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboarded random + directed bench for pc_gen against a deque-based reference model.
module tb_pc_gen;
  localparam logic [31:0] RST_A  = 32'h0000_3000;
  localparam logic [31:0] EXC_A  = 32'h0000_4180;
  localparam int          WORDS  = 4096;
  localparam int          DEPTH  = 4;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Br_Take, Jump, Ret, Ras_Push, Exc_Req, Eret;
  logic [31:0] Br_Target, Jump_Target, Ras_Push_Addr, Epc_In;
  logic [31:0] Pc, Pc_Plus4;
  logic [11:0] Pc_Idx;
  logic        Adel, Ras_Empty, Ras_Full;

  pc_gen dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Br_Take(Br_Take), .Br_Target(Br_Target),
    .Jump(Jump), .Jump_Target(Jump_Target), .Ret(Ret), .Ras_Push(Ras_Push),
    .Ras_Push_Addr(Ras_Push_Addr), .Exc_Req(Exc_Req), .Eret(Eret), .Epc_In(Epc_In),
    .Pc(Pc), .Pc_Plus4(Pc_Plus4), .Pc_Idx(Pc_Idx), .Adel(Adel),
    .Ras_Empty(Ras_Empty), .Ras_Full(Ras_Full)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus4;
    logic [11:0] idx;
    logic        adel;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic clr();
    Reset = 0; Stall = 0; Br_Take = 0; Jump = 0; Ret = 0; Ras_Push = 0; Exc_Req = 0; Eret = 0;
    Br_Target = 0; Jump_Target = 0; Ras_Push_Addr = 0; Epc_In = 0;
  endtask

  // Reference: stack as a deque, newest at the back, oldest dropped on overflow.
  task automatic model();
    logic [31:0] nxt;
    logic        pop;
    if (Reset) begin
      m_pc = RST_A;
      m_stk.delete();
    end else if (Exc_Req) m_pc = EXC_A;
    else if (Eret)        m_pc = Epc_In;
    else if (Stall)       m_pc = m_pc;
    else begin
      if (Ret)          nxt = (m_stk.size() > 0) ? m_stk[$] : Jump_Target;
      else if (Jump)    nxt = Jump_Target;
      else if (Br_Take) nxt = Br_Target;
      else              nxt = m_pc + 32'd4;
      pop = Ret && (m_stk.size() > 0);
      if (Ras_Push && pop) m_stk[m_stk.size()-1] = Ras_Push_Addr;
      else if (Ras_Push) begin
        m_stk.push_back(Ras_Push_Addr);
        if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
      end else if (pop) void'(m_stk.pop_back());
      m_pc = nxt;
    end
  endtask

  task automatic step();
    exp_t        e;
    logic [31:0] off;
    model();
    @(posedge Clk);
    #1;
    off     = m_pc - RST_A;
    e.pc    = m_pc;
    e.plus4 = m_pc + 32'd4;
    e.idx   = off[13:2];
    e.adel  = (m_pc[1:0] != 2'b00) || (m_pc < RST_A) || (m_pc >= RST_A + 4 * WORDS);
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == DEPTH);
    sb.push_back(e);
    clr();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pc",    Pc,                e.pc);
        check("plus4", Pc_Plus4,          e.plus4);
        check("idx",   {20'd0, Pc_Idx},   {20'd0, e.idx});
        check("adel",  {31'd0, Adel},     {31'd0, e.adel});
        check("empty", {31'd0, Ras_Empty}, {31'd0, e.empty});
        check("full",  {31'd0, Ras_Full},  {31'd0, e.full});
      end
    end
  end

  function automatic logic [31:0] rnd_tgt();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return RST_A + 4 * $urandom_range(0, WORDS - 1);
  endfunction

  initial begin : driver
    int waited;
    clr();
    m_pc = 32'hDEAD_BEEF;
    Reset = 1; step();
    repeat (3) step();
    // Stalled redirects are dropped; ID re-presents them after release.
    repeat (2) begin Stall = 1; Jump = 1; Jump_Target = 32'h3100; step(); end
    Jump = 1; Jump_Target = 32'h3100; step();
    Stall = 1; Exc_Req = 1; step();
    Eret = 1; Epc_In = 32'h3044; Jump = 1; Jump_Target = 32'h3200; step();
    Jump = 1; Jump_Target = 32'h3102; step();
    Jump = 1; Jump_Target = 32'h2FFC; step();
    Jump = 1; Jump_Target = RST_A + 4 * WORDS; step();
    Jump = 1; Jump_Target = RST_A + 4 * WORDS - 4; step();
    Br_Take = 1; Br_Target = 32'hFFFF_FFFC; step();
    step();
    Reset = 1; step();
    for (int i = 1; i <= 5; i++) begin Ras_Push = 1; Ras_Push_Addr = 32'h3000 + 32'h10 * i; step(); end
    repeat (4) begin Ret = 1; Jump_Target = 32'h3300; step(); end
    Ret = 1; Jump_Target = 32'h3200; step();
    Ras_Push = 1; Ras_Push_Addr = 32'h3010; step();
    Ras_Push = 1; Ras_Push_Addr = 32'h3020; Ret = 1; step();
    Ret = 1; step();
    for (int i = 0; i < 4; i++) begin Ras_Push = 1; Ras_Push_Addr = 32'h3400 + 4 * i; step(); end
    Stall = 1; Ras_Push = 1; Ras_Push_Addr = 32'h3500; Ret = 1; step();
    Ret = 1; Jump = 1; Jump_Target = 32'h3600; step();
    Reset = 1; Ret = 1; Ras_Push = 1; Ras_Push_Addr = 32'h3700; step();
    for (int i = 0; i < 600; i++) begin
      Reset         = ($urandom_range(0, 99) < 2);
      Exc_Req       = ($urandom_range(0, 39) == 0);
      Eret          = ($urandom_range(0, 39) == 0);
      Stall         = ($urandom_range(0, 5) == 0);
      Ret           = ($urandom_range(0, 5) == 0);
      Jump          = ($urandom_range(0, 7) == 0);
      Br_Take       = ($urandom_range(0, 4) == 0);
      Ras_Push      = ($urandom_range(0, 3) == 0);
      Jump_Target   = rnd_tgt();
      Br_Target     = rnd_tgt();
      Ras_Push_Addr = rnd_tgt();
      Epc_In        = rnd_tgt();
      step();
    end
    waited = 0;
    while (sb.size() != 0 && waited < 10) begin @(posedge Clk); waited++; end
    #6;
    check("drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
